// File: rtl/alu181_nibble_seq.sv
// Nibble-serial sequencer for a single external 74S181 slice: walks a WIDTH-bit
// operation through the slice LSB nibble first, chaining carry and A=B between nibbles.
module alu181_nibble_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op_s,
    input  logic             op_m,
    input  logic             op_cin_n,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout_n,
    output logic             aeb,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_s,
    output logic             alu_m,
    output logic             alu_cin_n,
    input  logic [3:0]       alu_f,
    input  logic             alu_cout_n,
    input  logic             alu_aeb
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W+1:0] base;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [3:0]       s_reg;
    logic             m_reg;
    logic             carry;
    logic             aeb_acc;
    logic             accept;

    assign base   = {idx, 2'b00};
    assign accept = (state == IDLE) && start;

    // The carry and A=B accumulators double as the held status outputs.
    assign cout_n = carry;
    assign aeb    = aeb_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        alu_a     = 4'h0;
        alu_b     = 4'h0;
        alu_s     = 4'h0;
        alu_m     = 1'b1;
        alu_cin_n = 1'b1;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy      = 1'b1;
                alu_a     = a_reg[base +: 4];
                alu_b     = b_reg[base +: 4];
                alu_s     = s_reg;
                alu_m     = m_reg;
                alu_cin_n = carry;
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            s_reg   <= 4'h0;
            m_reg   <= 1'b1;
            carry   <= 1'b1;
            aeb_acc <= 1'b0;
            result  <= '0;
        end else if (accept) begin
            idx     <= '0;
            a_reg   <= op_a;
            b_reg   <= op_b;
            s_reg   <= op_s;
            m_reg   <= op_m;
            carry   <= op_cin_n;
            aeb_acc <= 1'b1;
            result  <= '0;
        end else if (state == RUN) begin
            // Slice outputs settle within the nibble cycle and are captured here.
            result[base +: 4] <= alu_f;
            carry             <= alu_cout_n;
            aeb_acc           <= aeb_acc & alu_aeb;
            if (idx != LAST_IDX) begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu181_nibble_seq.sv
// Bench for alu181_nibble_seq: behavioural 74S181 slice in the loop, word-level
// reference model feeding a scoreboard queue checked by an independent monitor.
module tb_alu181_nibble_seq;

    localparam int WIDTH = 32;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [3:0]       op_s;
    logic             op_m;
    logic             op_cin_n;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout_n;
    logic             aeb;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [3:0]       alu_s;
    logic             alu_m;
    logic             alu_cin_n;
    logic [3:0]       alu_f;
    logic             alu_cout_n;
    logic             alu_aeb;

    typedef struct packed {
        logic [WIDTH-1:0] f;
        logic             cout_n;
        logic             aeb;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t last_e;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;

    alu181_nibble_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start),
        .op_s(op_s), .op_m(op_m), .op_cin_n(op_cin_n), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result), .cout_n(cout_n), .aeb(aeb),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cin_n(alu_cin_n),
        .alu_f(alu_f), .alu_cout_n(alu_cout_n), .alu_aeb(alu_aeb)
    );

    always #5 clk = ~clk;

    // Gate-level-equivalent 4-bit 74S181 (active-high data).
    function automatic logic [5:0] slice181(input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] s, input logic m,
                                            input logic cin_n);
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] f;
        logic [4:0] sum;
        x   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
        y   = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
        sum = {1'b0, x} + {1'b0, y} + {4'b0000, ~cin_n};
        f   = m ? ~(x ^ y) : sum[3:0];
        return {~sum[4], &f, f};
    endfunction

    always_comb {alu_cout_n, alu_aeb, alu_f} = slice181(alu_a, alu_b, alu_s, alu_m, alu_cin_n);

    // Whole-word reference from the 181 function table: arithmetic is "P plus Q plus carry".
    function automatic exp_t model_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      input logic [3:0] s, input logic m, input logic cin_n);
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] lf;
        logic [WIDTH-1:0] ones;
        logic [WIDTH:0]   sum;
        exp_t             e;
        ones = '1;
        q    = '0;
        case (s)
            4'd0:  p = a;
            4'd1:  p = a | b;
            4'd2:  p = a | ~b;
            4'd3:  p = ones;
            4'd4:  begin p = a;      q = a & ~b; end
            4'd5:  begin p = a | b;  q = a & ~b; end
            4'd6:  begin p = a;      q = ~b;     end
            4'd7:  begin p = a & ~b; q = ones;   end
            4'd8:  begin p = a;      q = a & b;  end
            4'd9:  begin p = a;      q = b;      end
            4'd10: begin p = a | ~b; q = a & b;  end
            4'd11: begin p = a & b;  q = ones;   end
            4'd12: begin p = a;      q = a;      end
            4'd13: begin p = a | b;  q = a;      end
            4'd14: begin p = a | ~b; q = a;      end
            default: begin p = a;    q = ones;   end
        endcase
        case (s)
            4'd0:  lf = ~a;
            4'd1:  lf = ~(a | b);
            4'd2:  lf = ~a & b;
            4'd3:  lf = '0;
            4'd4:  lf = ~(a & b);
            4'd5:  lf = ~b;
            4'd6:  lf = a ^ b;
            4'd7:  lf = a & ~b;
            4'd8:  lf = ~a | b;
            4'd9:  lf = ~(a ^ b);
            4'd10: lf = b;
            4'd11: lf = a & b;
            4'd12: lf = ones;
            4'd13: lf = a | ~b;
            4'd14: lf = a | b;
            default: lf = a;
        endcase
        sum      = {1'b0, p} + {1'b0, q} + {{WIDTH{1'b0}}, ~cin_n};
        e.f      = m ? lf : sum[WIDTH-1:0];
        e.cout_n = ~sum[WIDTH];
        e.aeb    = &e.f;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", {32'd0, result}, {32'd0, mon_e.f});
                check("cout_n", {63'd0, cout_n}, {63'd0, mon_e.cout_n});
                check("aeb", {63'd0, aeb}, {63'd0, mon_e.aeb});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [3:0] s, input logic m, input logic cin_n);
        op_a = a; op_b = b; op_s = s; op_m = m; op_cin_n = cin_n;
        start = 1'b1;
        tick();
        start = 1'b0;
        last_e = model_op(a, b, s, m, cin_n);
        exp_q.push_back(last_e);
        check("accept_busy", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_done(output int lat, output int busy_cycles);
        lat = 0;
        busy_cycles = busy ? 1 : 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
            if (busy) busy_cycles++;
        end
        if (!done) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [3:0] s, input logic m, input logic cin_n);
        int lat;
        int bc;
        do_op(a, b, s, m, cin_n);
        wait_done(lat, bc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int bc;
        int last_acc;
        int n_acc;
        int d0;
        int busy_seen;
        logic prev_busy;
        logic [WIDTH-1:0] ca;
        logic [WIDTH-1:0] cb;
        logic [WIDTH-1:0] xa;
        logic [WIDTH-1:0] xb;
        logic [3:0] cs;
        logic cm;
        logic cc;

        reset = 1'b1; start = 1'b0; op_s = 4'h0; op_m = 1'b0; op_cin_n = 1'b1;
        op_a = '0; op_b = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_result", {32'd0, result}, 64'd0);
        check("rst_cout_n", {63'd0, cout_n}, 64'd1);
        check("rst_aeb", {63'd0, aeb}, 64'd0);
        check("rst_alu_ab", {56'd0, alu_a, alu_b}, 64'd0);
        check("rst_alu_s", {60'd0, alu_s}, 64'd0);
        check("rst_alu_m_cin", {62'd0, alu_m, alu_cin_n}, 64'd3);

        // Add with carry ripple across the whole word; latency and busy width.
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 4'b1001, 1'b0, 1'b1);
        wait_done(lat, bc);
        check("add_latency_edges", lat, NIB);
        check("add_busy_cycles", bc, NIB);
        check("add_result", {32'd0, result}, 64'h0);
        check("add_cout_n", {63'd0, cout_n}, 64'd0);
        tick();

        run_op(32'd5, 32'd3, 4'b0110, 1'b0, 1'b0);
        check("sub1_result", {32'd0, result}, 64'h2);
        check("sub1_cout_n", {63'd0, cout_n}, 64'd0);
        tick();
        run_op(32'd3, 32'd5, 4'b0110, 1'b0, 1'b0);
        check("sub2_result", {32'd0, result}, 64'hFFFF_FFFE);
        check("sub2_cout_n", {63'd0, cout_n}, 64'd1);
        tick();
        run_op(32'h1234_5678, 32'h1234_5678, 4'b0110, 1'b0, 1'b1);
        check("cmp_eq_result", {32'd0, result}, 64'hFFFF_FFFF);
        check("cmp_eq_aeb", {63'd0, aeb}, 64'd1);
        tick();
        run_op(32'h1234_5678, 32'h1234_5679, 4'b0110, 1'b0, 1'b1);
        check("cmp_ne_aeb", {63'd0, aeb}, 64'd0);
        tick();

        // XOR: nibble presentation order, LSB first.
        xa = 32'hF0F0_A5A5;
        xb = 32'hFF00_FFFF;
        do_op(xa, xb, 4'b0110, 1'b1, 1'b1);
        for (int k = 0; k < NIB; k++) begin
            check("xor_alu_a", {60'd0, alu_a}, {60'd0, xa[4*k +: 4]});
            check("xor_alu_b", {60'd0, alu_b}, {60'd0, xb[4*k +: 4]});
            check("xor_alu_sm", {59'd0, alu_s, alu_m}, {59'd0, 4'b0110, 1'b1});
            tick();
        end
        check("xor_done", {63'd0, done}, 64'd1);
        check("xor_result", {32'd0, result}, 64'h0FF0_5A5A);
        repeat (3) tick();
        check("result_hold", {32'd0, result}, {32'd0, last_e.f});

        // Starts during RUN and DONE are dropped.
        d0 = done_cnt;
        do_op(32'h0000_00FF, 32'h0000_0001, 4'b1001, 1'b0, 1'b1);
        tick(); tick();
        start = 1'b1; op_a = 32'hDEAD_BEEF;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("ign_done_at_nib", {63'd0, done}, 64'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_seen = 0;
        repeat (15) begin
            tick();
            if (busy) busy_seen++;
        end
        check("ign_no_accept", busy_seen, 0);
        check("ign_single_done", done_cnt - d0, 1);
        check("ign_result", {32'd0, result}, 64'h100);

        // Start held high: one accept every NIB+2 cycles, inputs may change mid-op.
        ca = $urandom; cb = $urandom; cs = 4'($urandom); cm = 1'($urandom); cc = 1'($urandom);
        op_a = ca; op_b = cb; op_s = cs; op_m = cm; op_cin_n = cc;
        start = 1'b1;
        prev_busy = busy;
        last_acc = -1;
        n_acc = 0;
        for (int c = 0; c < 35; c++) begin
            tick();
            if (busy && !prev_busy) begin
                last_e = model_op(ca, cb, cs, cm, cc);
                exp_q.push_back(last_e);
                if (last_acc >= 0) check("issue_interval", c - last_acc, NIB + 2);
                last_acc = c;
                n_acc++;
                ca = $urandom; cb = $urandom; cs = 4'($urandom); cm = 1'($urandom); cc = 1'($urandom);
                op_a = ca; op_b = cb; op_s = cs; op_m = cm; op_cin_n = cc;
            end
            prev_busy = busy;
        end
        start = 1'b0;
        check("held_accepts", n_acc, 4);
        wait_done(lat, bc);
        tick();

        // Reset mid-operation aborts with no done pulse.
        d0 = done_cnt;
        do_op(32'h8765_4321, 32'h1111_1111, 4'b1001, 1'b0, 1'b0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_result", {32'd0, result}, 64'd0);
        check("abort_cout_aeb", {62'd0, cout_n, aeb}, 64'd2);
        check("abort_alu_cin_n", {63'd0, alu_cin_n}, 64'd1);
        exp_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rst_start_busy", {63'd0, busy}, 64'd0);
        reset = 1'b0;
        repeat (12) tick();
        check("abort_no_done", done_cnt - d0, 0);
        run_op(32'h0000_0010, 32'h0000_0020, 4'b1001, 1'b0, 1'b1);
        check("post_abort_result", {32'd0, result}, 64'h30);
        tick();

        // Random operations over all functions and modes.
        for (int i = 0; i < 24; i++) begin
            ca = $urandom;
            cb = (i % 6 == 0) ? ca : 32'($urandom);
            run_op(ca, cb, 4'($urandom), 1'($urandom), 1'($urandom));
            tick();
        end

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
